mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MEM-stage data-memory unit between the EX/MEM and MEM/WB pipeline registers. It takes the load/store control, ALU address, store data and funct3 carried through EX/MEM. It performs byte/half/word stores and loads with sign/zero extension against an internal word-addressed RAM that has a configurable read latency. While a load is outstanding it raises a stall to freeze PC, IF/ID, ID/EX and EX/MEM, and holds MEM/WB capture off.

Parameters:
ADDR_WIDTH, 10, word-index bits; RAM depth = 2^ADDR_WIDTH 32-bit words
READ_LATENCY, 1, cycles from load issue to data valid; legal 1..4

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
memread_mem  input  1  load request from EX/MEM
memwrite_mem  input  1  store request from EX/MEM
funct3_mem  input  3  access size/signedness (RV32I load/store funct3)
alu_result_mem  input  32  byte address
write_data_memory_mem  input  32  store data, right-aligned
data_from_memory_mem  output  32  load result to MEM/WB
mem_stall  output  1  pipeline freeze while a load is outstanding
misalign_err  output  1  one-cycle pulse for a misaligned access

Behaviour:
- Clock and reset: clk; reset rstn, synchronous, active-low.
- Word index = alu_result_mem[ADDR_WIDTH+1:2]; upper address bits are ignored (wrap-around).
- RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, DONE. Reset: state=IDLE, data_from_memory_mem=0, mem_stall=0, misalign_err=0, latency counter=0.
- Stores (IDLE only):
  - Committed on the clk edge when memwrite_mem=1 and memread_mem=0. No stall.
  - Byte enables: SB (000) writes lane addr[1:0] with wdata[7:0]. SH (001) writes lanes {addr[1],0},{addr[1],1} with wdata[15:0]. SW (010) writes all lanes.
  - Any other funct3: no write.
- Loads:
  - IDLE with memread_mem=1: mem_stall=1 combinationally in the same cycle; address and funct3 are latched.
  - If READ_LATENCY=1: IDLE->DONE. Otherwise: IDLE->WAIT, counter=READ_LATENCY-2; WAIT decrements; WAIT->DONE when counter==0.
  - mem_stall is high in IDLE(load) and WAIT, i.e. exactly READ_LATENCY cycles.
  - DONE: mem_stall=0; data_from_memory_mem is updated with the extracted load value at the edge entering DONE. DONE->IDLE unconditionally.
  - The request still present on the inputs in DONE is ignored, so the held load is not reissued.
- Load extraction from the latched address:
  - LB 000: sign-extended byte at addr[1:0]. LH 001: sign-extended half at addr[1]. LW 010: word.
  - LBU 100: zero-extended byte. LHU 101: zero-extended half.
  - Other funct3 values return 0.
- data_from_memory_mem is registered and holds its last value outside DONE.
- Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Store: suppressed (no RAM change); misalign_err pulses the cycle after.
  - Load: normal timing, result 0; misalign_err pulses in the DONE cycle.
- memread_mem and memwrite_mem both 1: treated as a load; the store is suppressed.
- Inputs are ignored in WAIT/DONE; the pipeline is held, so they still carry the outstanding load.
- Store at cycle N followed by a load of the same word at N+1: the load returns the new data (write-before-read).
- Reset mid-load: state returns to IDLE at that edge, mem_stall=0, data_from_memory_mem=0, no RAM write; RAM contents are preserved.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 with READ_LATENCY=1 -> mem_stall high exactly 1 cycle; data_from_memory_mem=0xDEADBEEF in DONE.
- SB 0x80 to addr 0x13, then LB 0x13 -> 0xFFFFFF80. LBU 0x13 -> 0x00000080. LW 0x10 -> 0x80ADBEEF.
- READ_LATENCY=3, LH from addr 0x12 holding 0x8001 -> mem_stall high 3 consecutive cycles; then 0xFFFF8001 for one DONE cycle; FSM back in IDLE the next cycle.
- SW to addr 0x11 -> RAM word unchanged, misalign_err one-cycle pulse. LW from 0x12 -> result 0, misalign_err pulses in DONE.
- With READ_LATENCY=4, rstn low during WAIT -> next cycle mem_stall=0, data_from_memory_mem=0, state IDLE. A following LW of a word written before reset returns the pre-reset value.
- Address 0x10 + 4*2^ADDR_WIDTH written by SW, then read via 0x10 -> same data (wrap-around).

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM-stage data-memory unit sitting between EX/MEM and MEM/WB. Performs
//   RV32I byte/half/word stores and sign/zero-extending loads against an
//   internal word-addressed RAM with a configurable read latency. While a
//   load is outstanding the pipeline is frozen through mem_stall.
//
// Ports
//   clk                    clock
//   rstn                   synchronous active-low reset
//   memread_mem            load request from EX/MEM
//   memwrite_mem           store request from EX/MEM
//   funct3_mem[2:0]        access size / signedness (RV32I funct3)
//   alu_result_mem[31:0]   byte address
//   write_data_memory_mem  store data, right-aligned
//   data_from_memory_mem   registered load result to MEM/WB
//   mem_stall              pipeline freeze while a load is outstanding
//   misalign_err           one-cycle pulse for a misaligned access
//   fsm_state[1:0]         debug view of the FSM (0 IDLE, 1 WAIT, 2 DONE)
//
// Handshake: a request is accepted only in IDLE. A load holds mem_stall high
// for exactly READ_LATENCY cycles (the issue cycle plus WAIT cycles); the
// upstream stages keep the request on the inputs while stalled, and the
// result appears in the single DONE cycle that follows, during which the
// still-present request is ignored.
module mem_access_stage #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_memory_mem,
  output logic [31:0] data_from_memory_mem,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] CNT_INIT = 2'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
  localparam int AW = ADDR_WIDTH + 2;

  logic [31:0]   ram [2**ADDR_WIDTH];
  logic [1:0]    state, state_next;
  logic [1:0]    cnt;
  logic [AW-1:0] lat_addr;
  logic [2:0]    lat_f3;
  logic [AW-1:0] acc_addr;
  logic [2:0]    acc_f3;
  logic [31:0]   rd_word;
  logic          load_issue, store_fire, st_mis, enter_done;
  logic [3:0]    be;
  logic [31:0]   wlane;

  // Upper address bits are intentionally dropped (address wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result_mem[31:AW];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b010:  extract = w;
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = 32'd0;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: load_misaligned = a[0];
      3'b010:         load_misaligned = (a != 2'b00);
      default:        load_misaligned = 1'b0;
    endcase
  endfunction

  // Requests are taken from the inputs in IDLE and from the latched copy later.
  assign acc_addr   = (state == S_IDLE) ? alu_result_mem[AW-1:0] : lat_addr;
  assign acc_f3     = (state == S_IDLE) ? funct3_mem : lat_f3;
  assign rd_word    = ram[acc_addr[AW-1:2]];
  assign load_issue = (state == S_IDLE) && memread_mem;
  assign store_fire = (state == S_IDLE) && memwrite_mem && !memread_mem;
  assign enter_done = (state != S_DONE) && (state_next == S_DONE);

  // Store lane steering; misaligned stores are dropped entirely.
  always_comb begin
    be     = 4'b0000;
    wlane  = write_data_memory_mem;
    st_mis = 1'b0;
    case (funct3_mem)
      3'b000: begin
        be    = 4'b0001 << alu_result_mem[1:0];
        wlane = {4{write_data_memory_mem[7:0]}};
      end
      3'b001: begin
        st_mis = alu_result_mem[0];
        be     = alu_result_mem[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{write_data_memory_mem[15:0]}};
      end
      3'b010: begin
        st_mis = (alu_result_mem[1:0] != 2'b00);
        be     = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (memread_mem) state_next = (READ_LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt == 2'd0) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_stall = load_issue || (state == S_WAIT);
    fsm_state = state;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt                  <= 2'd0;
      lat_addr             <= '0;
      lat_f3               <= 3'd0;
      data_from_memory_mem <= 32'd0;
      misalign_err         <= 1'b0;
    end else begin
      misalign_err <= store_fire && st_mis;
      if (load_issue) begin
        lat_addr <= alu_result_mem[AW-1:0];
        lat_f3   <= funct3_mem;
        cnt      <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end
      if (enter_done) begin
        misalign_err <= load_misaligned(acc_f3, acc_addr[1:0]);
        data_from_memory_mem <= load_misaligned(acc_f3, acc_addr[1:0]) ? 32'd0
                              : extract(rd_word, acc_f3, acc_addr[1:0]);
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rstn && store_fire && !st_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[alu_result_mem[AW-1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances with read latencies 1, 3 and 4,
// each with its own input set, checked against a word-array reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd    [3];
  logic        wr    [3];
  logic [2:0]  f3s   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [31:0] dout  [3];
  logic        stall [3];
  logic        mis_o [3];
  logic [1:0]  st_o  [3];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mdl  [3][1024];
  logic [31:0] last [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_stage #(
      .ADDR_WIDTH(10),
      .READ_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .memread_mem          (rd[g]),
      .memwrite_mem         (wr[g]),
      .funct3_mem           (f3s[g]),
      .alu_result_mem       (addr[g]),
      .write_data_memory_mem(wdat[g]),
      .data_from_memory_mem (dout[g]),
      .mem_stall            (stall[g]),
      .misalign_err         (mis_o[g]),
      .fsm_state            (st_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules, expressed as plain arithmetic on byte addresses.
  function automatic int widx(input logic [31:0] a);
    return (a / 4) % 1024;
  endfunction

  function automatic bit ld_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 0;
  endfunction

  function automatic bit st_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    if (ld_mis(f3, a)) return 32'd0;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input int d, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    logic [31:0] w, m;
    int sh;
    w = mdl[d][widx(a)];
    if (st_mis(f3, a)) return;
    case (f3)
      3'b000: begin sh = 8 * (a % 4);        m = 32'hFF << sh;   end
      3'b001: begin sh = 16 * ((a / 2) % 2); m = 32'hFFFF << sh; end
      3'b010: begin sh = 0;                  m = 32'hFFFF_FFFF;  end
      default: return;
    endcase
    mdl[d][widx(a)] = (w & ~m) | ((wd << sh) & m);
  endtask

  task automatic do_store(input int d, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit settle);
    bit em;
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b1; f3s[d] = f3; addr[d] = a; wdat[d] = wd;
    #1 chk("st_stall", 32'(stall[d]), 32'd0);
    em = st_mis(f3, a);
    model_store(d, f3, a, wd);
    @(posedge clk); #1;
    wr[d] = 1'b0;
    chk("st_mis", 32'(mis_o[d]), 32'(em));
    if (settle) begin
      @(posedge clk); #1 chk("st_mis_clr", 32'(mis_o[d]), 32'd0);
    end
  endtask

  task automatic do_load(input int d, input logic [2:0] f3, input logic [31:0] a,
                         input bit also_wr);
    logic [31:0] ev;
    bit em;
    @(negedge clk);
    rd[d] = 1'b1; wr[d] = also_wr; f3s[d] = f3; addr[d] = a; wdat[d] = $urandom;
    #1 chk("ld_stall_issue", 32'(stall[d]), 32'd1);
    ev = ld_val(mdl[d][widx(a)], f3, a);
    em = ld_mis(f3, a);
    for (int k = 1; k < lat_of(d); k++) begin
      @(posedge clk); #1;
      chk("ld_stall_wait", 32'(stall[d]), 32'd1);
      chk("ld_state_wait", 32'(st_o[d]), 32'd1);
    end
    @(posedge clk); #1;
    chk("ld_stall_done", 32'(stall[d]), 32'd0);
    chk("ld_state_done", 32'(st_o[d]), 32'd2);
    chk("ld_data", dout[d], ev);
    chk("ld_mis", 32'(mis_o[d]), 32'(em));
    last[d] = ev;
    @(posedge clk); #1;
    chk("ld_state_idle", 32'(st_o[d]), 32'd0);
    rd[d] = 1'b0; wr[d] = 1'b0;
    #1;
    chk("ld_stall_idle", 32'(stall[d]), 32'd0);
    chk("ld_hold", dout[d], last[d]);
  endtask

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rd[d] = 0; wr[d] = 0; f3s[d] = 0; addr[d] = 0; wdat[d] = 0; last[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_data", dout[d], 32'd0);
      chk("rst_stall", 32'(stall[d]), 32'd0);
      chk("rst_mis", 32'(mis_o[d]), 32'd0);
      chk("rst_state", 32'(st_o[d]), 32'd0);
    end
    rstn = 1'b1;

    // Latency 1: word, byte and wrap-around accesses
    do_store(0, 3'b010, 32'h10, 32'hDEADBEEF, 1);
    do_load (0, 3'b010, 32'h10, 0);
    do_store(0, 3'b000, 32'h13, 32'h00000080, 1);
    do_load (0, 3'b000, 32'h13, 0);
    do_load (0, 3'b100, 32'h13, 0);
    do_load (0, 3'b010, 32'h10, 0);
    do_store(0, 3'b010, 32'h11, 32'h11111111, 1);
    do_load (0, 3'b010, 32'h10, 0);
    do_load (0, 3'b010, 32'h12, 0);
    do_store(0, 3'b010, 32'h10 + 32'd4096, 32'h12345678, 1);
    do_load (0, 3'b010, 32'h10, 0);
    do_load (0, 3'b010, 32'h10, 1);   // both requests: the store is dropped
    do_load (0, 3'b010, 32'h10, 0);

    // Latency 3: half loads, store immediately followed by a load
    do_store(1, 3'b001, 32'h12, 32'h00008001, 0);
    do_load (1, 3'b001, 32'h12, 0);
    do_load (1, 3'b101, 32'h12, 0);
    do_load (1, 3'b001, 32'h13, 0);

    // Latency 4: reset while waiting, RAM contents survive
    do_store(2, 3'b010, 32'h20, 32'hAAAA5555, 1);
    @(negedge clk);
    rd[2] = 1'b1; f3s[2] = 3'b010; addr[2] = 32'h20;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0; rd[2] = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_stall", 32'(stall[2]), 32'd0);
    chk("rst_mid_data", dout[2], 32'd0);
    chk("rst_mid_state", 32'(st_o[2]), 32'd0);
    rstn = 1'b1;
    for (int d = 0; d < 3; d++) last[d] = 32'd0;
    do_load(2, 3'b010, 32'h20, 0);

    // Randomized traffic on every instance within a 16-word window
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) do_store(d, 3'b010, 32'(4 * w), $urandom, 0);
      for (int n = 0; n < 30; n++) begin
        int op;
        logic [2:0] f3;
        logic [31:0] a;
        op = $urandom_range(0, 2);
        f3 = 3'($urandom_range(0, 7));
        a  = 32'($urandom_range(0, 63)) + 32'h1000 * 32'($urandom_range(0, 3));
        if (op == 0) do_store(d, f3, a, $urandom, 1);
        else         do_load(d, f3, a, op == 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
